// File: rtl/uu_acmac_crc32_mb.sv
// Multi-byte CRC-32 (IEEE 802.3) engine: GEN produces the FCS, CHK compares the
// final register against the good-frame residue. DATA_BYTES bytes per beat.
module uu_acmac_crc32_mb #(
  parameter int          DATA_BYTES = 4,
  parameter int          LEN_W      = 16,
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE    = 32'hC704_DD7B
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_crc_en,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [LEN_W-1:0]          i_len,
  input  logic                      i_data_val,
  input  logic [8*DATA_BYTES-1:0]   i_data,
  output logic                      o_data_rdy,
  output logic                      o_busy,
  output logic [LEN_W-1:0]          o_byte_cnt,
  output logic                      o_crc_avl,
  output logic [31:0]               o_crc,
  output logic                      o_crc_ok,
  output logic                      o_crc_err
);

  localparam logic [31:0]      POLY = 32'h04C1_1DB7;
  localparam logic [LEN_W-1:0] BEAT = LEN_W'(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_mode;
  logic [31:0]      r_reg;
  logic             r_avl;
  logic [31:0]      r_crc;
  logic             r_ok;
  logic             r_err;

  logic [LEN_W-1:0] w_rem;
  logic [LEN_W-1:0] w_n;
  logic [LEN_W-1:0] w_cnt;
  logic [31:0]      w_reg;

  // Ethernet sends bit 0 first, so byte bit i enters the MSB-first register at 31-i.
  function automatic logic [31:0] f_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r[31-i] = c[31-i] ^ b[i];
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] f_fcs(input logic [31:0] r);
    logic [31:0] f;
    for (int i = 0; i < 32; i++) f[i] = ~r[31-i];
    return f;
  endfunction

  always_comb begin
    w_rem = r_len - r_cnt;
    w_n   = (w_rem < BEAT) ? w_rem : BEAT;
    w_cnt = r_cnt + w_n;
    w_reg = r_reg;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (LEN_W'(k) < w_n) w_reg = f_byte(w_reg, i_data[8*k +: 8]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_crc_en) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_reg   <= '0;
      r_avl   <= 1'b0;
      r_crc   <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state != RUN) begin
      // IDLE and DONE both accept a start; DONE is the back-to-back path.
      if (i_start) begin
        r_len  <= i_len;
        r_mode <= i_mode;
        r_reg  <= CRC_INIT;
        r_cnt  <= '0;
        if (i_len == '0) begin
          r_state <= DONE;
          r_avl   <= 1'b1;
          r_crc   <= f_fcs(CRC_INIT);
          r_ok    <= i_mode && (CRC_INIT == RESIDUE);
          r_err   <= i_mode && (CRC_INIT != RESIDUE);
        end else begin
          r_state <= RUN;
          r_avl   <= 1'b0;
          r_ok    <= 1'b0;
          r_err   <= 1'b0;
        end
      end
    end else if (i_data_val) begin
      r_reg <= w_reg;
      r_cnt <= w_cnt;
      if (w_cnt == r_len) begin
        r_state <= DONE;
        r_avl   <= 1'b1;
        r_crc   <= f_fcs(w_reg);
        r_ok    <= r_mode && (w_reg == RESIDUE);
        r_err   <= r_mode && (w_reg != RESIDUE);
      end
    end
  end

  assign o_data_rdy = (r_state == RUN);
  assign o_busy     = (r_state == RUN);
  assign o_byte_cnt = r_cnt;
  assign o_crc_avl  = r_avl;
  assign o_crc      = r_crc;
  assign o_crc_ok   = r_ok;
  assign o_crc_err  = r_err;

endmodule

// File: tb/tb_uu_acmac_crc32_mb.sv
// Bench for uu_acmac_crc32_mb: fixed vector table, mid-frame reset/disable,
// and random frames against a reflected (LSB-first) CRC-32 reference.
module tb_uu_acmac_crc32_mb;

  localparam int DB = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          crcEn;
  logic          start;
  logic          mode;
  logic [LW-1:0] len;
  logic          dataVal;
  logic [8*DB-1:0] data;
  logic          dataRdy;
  logic          busy;
  logic [LW-1:0] byteCnt;
  logic          crcAvl;
  logic [31:0]   crc;
  logic          crcOk;
  logic          crcErr;

  int errors = 0;
  int checks = 0;

  logic [7:0] fb [0:255];

  typedef struct {
    bit          m;
    int          n;
    logic [7:0]  b [16];
    bit          chkCrc;
    logic [31:0] expCrc;
    logic        expOk;
    logic        expErr;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  uu_acmac_crc32_mb #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_crc_en   (crcEn),
    .i_start    (start),
    .i_mode     (mode),
    .i_len      (len),
    .i_data_val (dataVal),
    .i_data     (data),
    .o_data_rdy (dataRdy),
    .o_busy     (busy),
    .o_byte_cnt (byteCnt),
    .o_crc_avl  (crcAvl),
    .o_crc      (crc),
    .o_crc_ok   (crcOk),
    .o_crc_err  (crcErr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Standard reflected CRC-32 over fb[0..n-1], returned as the transmitted FCS value.
  function automatic logic [31:0] refCrc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic loadCheck;
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
  endtask

  // Runs one frame from fb; the DUT is expected to be in IDLE or DONE on entry.
  task automatic applyStimulus(input bit m, input int n, input bit gaps, input bit noise,
                               output logic [31:0] gotCrc, output logic gotOk, output logic gotErr);
    int idx;
    int guard;
    bit rdyDrop;
    bit early;
    idx = 0; guard = 0; rdyDrop = 0; early = 0;
    start = 1'b1; mode = m; len = LW'(n); dataVal = 1'b0;
    tick;
    start = 1'b0;
    if (n == 0) begin
      checkOutput("len0 avl", {31'h0, crcAvl}, 32'h1);
    end else begin
      checkOutput("run flags rdy/busy/avl", {29'h0, dataRdy, busy, crcAvl}, 32'h6);
      while (idx < n && guard < 2000) begin
        guard++;
        if (!dataRdy) rdyDrop = 1;
        if (crcAvl) early = 1;
        if (gaps && $urandom_range(0, 2) == 0) begin
          dataVal = 1'b0;
          data = $urandom;
        end else begin
          dataVal = 1'b1;
          for (int k = 0; k < DB; k++)
            data[8*k +: 8] = (idx + k < n) ? fb[idx + k] : 8'($urandom);
        end
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick;
        if (dataVal) idx += DB;
      end
      dataVal = 1'b0;
      start = 1'b0;
      checkOutput("beat loop bound", {31'h0, idx >= n}, 32'h1);
      checkOutput("data_rdy held in RUN", {31'h0, rdyDrop}, 32'h0);
      checkOutput("crc_avl early", {31'h0, early}, 32'h0);
      checkOutput("crc_avl latency", {31'h0, crcAvl}, 32'h1);
    end
    checkOutput("byte_cnt", {16'h0, byteCnt}, 32'(n));
    gotCrc = crc;
    gotOk  = crcOk;
    gotErr = crcErr;
  endtask

  task automatic checkCleared(input string name);
    checkOutput(name, {byteCnt, 10'h0, dataRdy, busy, crcAvl, crcOk, crcErr, 1'b0}, 32'h0);
    checkOutput({name, " crc"}, crc, 32'h0);
  endtask

  initial begin
    logic [31:0] gCrc;
    logic        gOk;
    logic        gErr;
    logic [31:0] fcs;
    int          dLen;
    bit          corrupt;
    bit          m;

    rstN = 1'b0; crcEn = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
    dataVal = 1'b0; data = '0;
    tick;
    tick;
    checkCleared("reset state");
    rstN = 1'b1;
    tick;

    for (int v = 0; v < 6; v++)
      for (int i = 0; i < 16; i++) vecs[v].b[i] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      vecs[0].b[i] = 8'h31 + 8'(i);
      vecs[1].b[i] = 8'h31 + 8'(i);
      vecs[2].b[i] = 8'h31 + 8'(i);
    end
    vecs[1].b[9] = 8'h26; vecs[1].b[10] = 8'h39; vecs[1].b[11] = 8'hF4; vecs[1].b[12] = 8'hCB;
    vecs[2].b[9] = 8'h26; vecs[2].b[10] = 8'h39; vecs[2].b[11] = 8'hF4; vecs[2].b[12] = 8'hCB;
    vecs[2].b[3] = 8'h35;
    vecs[5].b[0] = 8'h61;
    vecs[0].m = 0; vecs[0].n = 9;  vecs[0].chkCrc = 1; vecs[0].expCrc = 32'hCBF4_3926; vecs[0].expOk = 0; vecs[0].expErr = 0;
    vecs[1].m = 1; vecs[1].n = 13; vecs[1].chkCrc = 1; vecs[1].expCrc = 32'h2144_DF1C; vecs[1].expOk = 1; vecs[1].expErr = 0;
    vecs[2].m = 1; vecs[2].n = 13; vecs[2].chkCrc = 0; vecs[2].expCrc = 32'h0;         vecs[2].expOk = 0; vecs[2].expErr = 1;
    vecs[3].m = 0; vecs[3].n = 0;  vecs[3].chkCrc = 1; vecs[3].expCrc = 32'h0;         vecs[3].expOk = 0; vecs[3].expErr = 0;
    vecs[4].m = 1; vecs[4].n = 0;  vecs[4].chkCrc = 1; vecs[4].expCrc = 32'h0;         vecs[4].expOk = 0; vecs[4].expErr = 1;
    vecs[5].m = 0; vecs[5].n = 1;  vecs[5].chkCrc = 1; vecs[5].expCrc = 32'hE8B7_BE43; vecs[5].expOk = 0; vecs[5].expErr = 0;

    // Table rows run back-to-back: each start lands in DONE of the previous frame.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) fb[i] = vecs[v].b[i];
      applyStimulus(vecs[v].m, vecs[v].n, 0, 0, gCrc, gOk, gErr);
      if (vecs[v].chkCrc) checkOutput($sformatf("vec%0d crc", v), gCrc, vecs[v].expCrc);
      checkOutput($sformatf("vec%0d ok/err", v), {30'h0, gOk, gErr}, {30'h0, vecs[v].expOk, vecs[v].expErr});
    end

    loadCheck();
    applyStimulus(0, 9, 1, 1, gCrc, gOk, gErr);
    checkOutput("gaps+start noise crc", gCrc, 32'hCBF4_3926);

    // Abort mid-frame, first by reset then by crc_en, each with start/data held active.
    for (int pass = 0; pass < 2; pass++) begin
      loadCheck();
      start = 1'b1; mode = 1'b0; len = 16'd9;
      tick;
      start = 1'b0; dataVal = 1'b1; data = 32'h3433_3231;
      tick;
      if (pass == 0) rstN = 1'b0; else crcEn = 1'b0;
      start = 1'b1; dataVal = 1'b1;
      tick;
      rstN = 1'b1; crcEn = 1'b1; start = 1'b0; dataVal = 1'b0;
      checkCleared(pass == 0 ? "mid-frame reset" : "mid-frame disable");
      applyStimulus(0, 9, 0, 0, gCrc, gOk, gErr);
      checkOutput(pass == 0 ? "after reset crc" : "after disable crc", gCrc, 32'hCBF4_3926);
    end

    // Back-to-back: a start in DONE must drop crc_avl on the next cycle.
    loadCheck();
    applyStimulus(1, 9, 0, 0, gCrc, gOk, gErr);
    checkOutput("chk short frame err", {30'h0, gOk, gErr}, {30'h0, 2'b01});
    applyStimulus(0, 9, 0, 0, gCrc, gOk, gErr);
    checkOutput("back-to-back crc", gCrc, 32'hCBF4_3926);

    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom_range(0, 1));
      if (!m) begin
        dLen = $urandom_range(0, 40);
        for (int i = 0; i < dLen; i++) fb[i] = 8'($urandom);
        applyStimulus(0, dLen, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gCrc, gOk, gErr);
        checkOutput($sformatf("rand%0d gen crc", t), gCrc, refCrc(dLen));
        checkOutput($sformatf("rand%0d gen ok/err", t), {30'h0, gOk, gErr}, 32'h0);
      end else begin
        dLen = $urandom_range(1, 36);
        for (int i = 0; i < dLen; i++) fb[i] = 8'($urandom);
        fcs = refCrc(dLen);
        for (int i = 0; i < 4; i++) fb[dLen + i] = fcs[8*i +: 8];
        corrupt = 1'($urandom_range(0, 1));
        if (corrupt) begin
          int pos;
          pos = $urandom_range(0, dLen + 3);
          fb[pos] = fb[pos] ^ (8'h01 << $urandom_range(0, 7));
        end
        applyStimulus(1, dLen + 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gCrc, gOk, gErr);
        checkOutput($sformatf("rand%0d chk crc", t), gCrc, refCrc(dLen + 4));
        checkOutput($sformatf("rand%0d chk ok/err", t), {30'h0, gOk, gErr}, {30'h0, !corrupt, corrupt});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
